exception_ctrl: RTL and testbench

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl.sv | 174 +++++++++++++++++
 tb/tb_exception_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// Exception / interrupt controller. It arbitrates one software exception slot
// and NCH external interrupt channels, presents one vector at a time to the
// CPU, and tracks the CPU's service of that vector through IDLE/REQ/SERVICE.
//
// Handshake: exception/vector form a request that is held stable while in REQ;
// ack is sampled only in REQ and completes the transfer on that edge (ack wins
// over a simultaneous ie drop). eoi is sampled only in SERVICE. Strobes seen in
// any other state have no effect.
module exception_ctrl #(
    parameter int NCH      = 8,
    parameter int VW       = 5,
    parameter int IRQ_BASE = 8,
    parameter int EXC_MIN  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ie,
    input  logic [NCH-1:0] irq_n,
    input  logic           exc_valid,
    input  logic [VW-1:0]  exc_vec,
    input  logic           mask_we,
    input  logic [NCH-1:0] mask_wdata,
    input  logic           ack,
    input  logic           eoi,
    output logic           exception,
    output logic [VW-1:0]  vector,
    output logic           iack_n,
    output logic [NCH-1:0] pending,
    output logic           busy,
    output logic           exc_ovf,
    output logic [1:0]     state_dbg
);

    localparam int            CW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [VW-1:0] IRQ_BASE_V = VW'(IRQ_BASE);
    localparam logic [VW-1:0] EXC_MIN_V  = VW'(EXC_MIN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] sync1_q, sync2_q, sync3_q;
    logic [NCH-1:0] pending_q, mask_q;
    logic           slot_valid_q;
    logic [VW-1:0]  slot_vec_q;
    logic           ovf_q;
    logic [VW-1:0]  vec_q;
    logic           src_slot_q;
    logic [CW-1:0]  src_ch_q;
    logic           iack_q;

    logic [NCH-1:0] irq_fall, selectable, clr_pend;
    logic           win_found;
    logic [CW-1:0]  win_ch;
    logic           load_sel, do_ack, clr_slot, exc_accept;

    assign irq_fall   = sync3_q & ~sync2_q;
    assign selectable = pending_q & ~mask_q;
    assign clr_slot   = do_ack & src_slot_q;
    assign exc_accept = exc_valid && (exc_vec >= EXC_MIN_V);

    // Lowest-index unmasked pending channel wins among the external lines.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (selectable[i]) begin
                win_found = 1'b1;
                win_ch    = CW'(i);
            end
        end
    end

    // Pending bit to retire when the CPU accepts a channel request.
    always_comb begin
        clr_pend = '0;
        if (do_ack && !src_slot_q) clr_pend[src_ch_q] = 1'b1;
    end

    // Next-state logic for the request/service sequencer.
    always_comb begin
        state_d  = state_q;
        load_sel = 1'b0;
        do_ack   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ie && (slot_valid_q || win_found)) begin
                    load_sel = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    do_ack  = 1'b1;
                    state_d = ST_SERVICE;
                end else if (!ie) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, captured winner and the one-cycle acknowledge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            src_slot_q <= 1'b0;
            src_ch_q   <= '0;
            iack_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            iack_q  <= ~do_ack;
            if (load_sel) begin
                vec_q      <= slot_valid_q ? slot_vec_q : IRQ_BASE_V + VW'(win_ch);
                src_slot_q <= slot_valid_q;
                src_ch_q   <= win_ch;
            end
        end
    end

    // Synchronizers idle high; a falling edge latches pending, set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            sync3_q   <= '1;
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            sync1_q   <= irq_n;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= (pending_q & ~clr_pend) | irq_fall;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    // One-entry software slot; a slot freed this cycle may take a new vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_vec_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            if (exc_accept) begin
                if (slot_valid_q && !clr_slot) begin
                    ovf_q <= 1'b1;
                end else begin
                    slot_valid_q <= 1'b1;
                    slot_vec_q   <= exc_vec;
                end
            end else if (clr_slot) begin
                slot_valid_q <= 1'b0;
            end
        end
    end

    assign exception = (state_q == ST_REQ);
    assign vector    = exception ? vec_q : '0;
    assign busy      = (state_q == ST_SERVICE);
    assign iack_n    = iack_q;
    assign pending   = pending_q;
    assign exc_ovf   = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed scenarios followed by randomized traffic,
// all checked each cycle against a rule-level reference model.
module tb_exception_ctrl;

    localparam int NCH      = 8;
    localparam int VW       = 5;
    localparam int IRQ_BASE = 8;
    localparam int EXC_MIN  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           ie;
    logic [NCH-1:0] irq_n;
    logic           exc_valid;
    logic [VW-1:0]  exc_vec;
    logic           mask_we;
    logic [NCH-1:0] mask_wdata;
    logic           ack;
    logic           eoi;
    logic           exception;
    logic [VW-1:0]  vector;
    logic           iack_n;
    logic [NCH-1:0] pending;
    logic           busy;
    logic           exc_ovf;
    logic [1:0]     state_dbg;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, phrased in terms of the rules.
    localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
    int             m_mode;
    int             m_slot;     // -1 when empty, else the stored vector
    bit             m_ovf;
    bit [NCH-1:0]   m_pend;
    bit [NCH-1:0]   m_mask;
    int             m_vec;
    int             m_src;      // -1 = software slot, else channel number
    bit             m_iack_n;
    bit [NCH-1:0]   hist[3];    // irq_n as sampled 1, 2, 3 edges ago

    exception_ctrl #(
        .NCH(NCH), .VW(VW), .IRQ_BASE(IRQ_BASE), .EXC_MIN(EXC_MIN)
    ) dut (
        .clk(clk), .rst(rst), .ie(ie), .irq_n(irq_n),
        .exc_valid(exc_valid), .exc_vec(exc_vec),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .ack(ack), .eoi(eoi),
        .exception(exception), .vector(vector), .iack_n(iack_n),
        .pending(pending), .busy(busy), .exc_ovf(exc_ovf),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode   = M_IDLE;
        m_slot   = -1;
        m_ovf    = 1'b0;
        m_pend   = '0;
        m_mask   = '1;
        m_vec    = 0;
        m_src    = 0;
        m_iack_n = 1'b1;
        for (int k = 0; k < 3; k++) hist[k] = '1;
    endfunction

    // Advance the model by one rising edge using the inputs the DUT saw.
    function automatic void model_edge();
        bit [NCH-1:0] fall, sel, clr;
        int           win, n_mode;
        bit           clr_slot, n_iack;
        fall     = ~hist[1] & hist[2];
        sel      = m_pend & ~m_mask;
        win      = -1;
        for (int i = 0; i < NCH; i++) if (win < 0 && sel[i]) win = i;
        clr      = '0;
        clr_slot = 1'b0;
        n_iack   = 1'b1;
        n_mode   = m_mode;
        if (m_mode == M_IDLE) begin
            if (ie && (m_slot >= 0 || win >= 0)) begin
                n_mode = M_REQ;
                if (m_slot >= 0) begin
                    m_vec = m_slot;
                    m_src = -1;
                end else begin
                    m_vec = IRQ_BASE + win;
                    m_src = win;
                end
            end
        end else if (m_mode == M_REQ) begin
            if (ack) begin
                n_mode = M_SVC;
                n_iack = 1'b0;
                if (m_src < 0) clr_slot = 1'b1;
                else clr[m_src] = 1'b1;
            end else if (!ie) begin
                n_mode = M_IDLE;
            end
        end else begin
            if (eoi) n_mode = M_IDLE;
        end
        if (exc_valid && int'(exc_vec) >= EXC_MIN) begin
            if (m_slot >= 0 && !clr_slot) m_ovf = 1'b1;
            else m_slot = int'(exc_vec);
        end else if (clr_slot) begin
            m_slot = -1;
        end
        m_pend = (m_pend & ~clr) | fall;
        if (mask_we) m_mask = mask_wdata;
        hist[2]  = hist[1];
        hist[1]  = hist[0];
        hist[0]  = irq_n;
        m_mode   = n_mode;
        m_iack_n = n_iack;
    endfunction

    task automatic check_all();
        chk("exception", 32'(exception), 32'(m_mode == M_REQ));
        chk("vector",    32'(vector),    (m_mode == M_REQ) ? 32'(m_vec) : 32'd0);
        chk("iack_n",    32'(iack_n),    32'(m_iack_n));
        chk("pending",   32'(pending),   32'(m_pend));
        chk("busy",      32'(busy),      32'(m_mode == M_SVC));
        chk("exc_ovf",   32'(exc_ovf),   32'(m_ovf));
    endtask

    // Driver: one clock, then check outputs at the falling edge, drop strobes.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_all();
        exc_valid = 1'b0;
        mask_we   = 1'b0;
        ack       = 1'b0;
        eoi       = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_iack_n", 32'(iack_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ie = 1'b0; irq_n = '1; exc_valid = 1'b0; exc_vec = '0;
        mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        chk("reset_vector", 32'(vector), 32'd0);
        rst = 1'b0;

        // Channel 3 request through full service.
        ie = 1'b1; mask_we = 1'b1; mask_wdata = '0;
        cycle();
        irq_n[3] = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("s1_pend3_edge3", 32'(pending[3]), 32'd1);
        chk("s1_noexc_edge3", 32'(exception), 32'd0);
        cycle();
        chk("s1_exc_edge4", 32'(exception), 32'd1);
        chk("s1_vec11", 32'(vector), 32'd11);
        ack = 1'b1;
        cycle();
        chk("s1_iack_low", 32'(iack_n), 32'd0);
        chk("s1_pend3_clr", 32'(pending[3]), 32'd0);
        chk("s1_busy", 32'(busy), 32'd1);
        cycle();
        chk("s1_iack_one_cycle", 32'(iack_n), 32'd1);
        eoi = 1'b1;
        cycle();
        chk("s1_idle", 32'(busy), 32'd0);
        irq_n[3] = 1'b1;

        // Software slot beats a pending channel.
        ie = 1'b0; irq_n[5] = 1'b0;
        repeat (3) cycle();
        exc_valid = 1'b1; exc_vec = VW'(6);
        cycle();
        ie = 1'b1;
        cycle();
        chk("s2_first_vec6", 32'(vector), 32'd6);
        ack = 1'b1;
        cycle();
        eoi = 1'b1;
        cycle();
        cycle();
        chk("s2_second_vec13", 32'(vector), 32'd13);
        ack = 1'b1;
        cycle();
        eoi = 1'b1;
        cycle();
        irq_n[5] = 1'b1;

        // Below-minimum vector ignored; overflow keeps the first vector.
        ie = 1'b0;
        exc_valid = 1'b1; exc_vec = VW'(2);
        cycle();
        chk("s3_low_vec_ovf", 32'(exc_ovf), 32'd0);
        exc_valid = 1'b1; exc_vec = VW'(6);
        cycle();
        exc_valid = 1'b1; exc_vec = VW'(7);
        cycle();
        exc_valid = 1'b1; exc_vec = VW'(9);
        cycle();
        chk("s3_ovf", 32'(exc_ovf), 32'd1);
        ie = 1'b1;
        cycle();
        chk("s3_retained_vec6", 32'(vector), 32'd6);
        ack = 1'b1;
        cycle();
        eoi = 1'b1;
        cycle();

        // Masked channel held off until the mask opens; ie drop and re-present.
        pulse_rst();
        ie = 1'b1; irq_n[0] = 1'b0;
        repeat (5) cycle();
        chk("s4_pend0", 32'(pending[0]), 32'd1);
        chk("s4_masked", 32'(exception), 32'd0);
        mask_we = 1'b1; mask_wdata = '0;
        cycle();
        chk("s4_not_yet", 32'(exception), 32'd0);
        cycle();
        chk("s4_vec8", 32'(vector), 32'd8);
        ie = 1'b0;
        cycle();
        chk("s5_withdrawn", 32'(exception), 32'd0);
        chk("s5_pend_kept", 32'(pending[0]), 32'd1);
        ie = 1'b1;
        cycle();
        chk("s5_represent_vec8", 32'(vector), 32'd8);
        ack = 1'b1;
        cycle();
        chk("s6_in_service", 32'(busy), 32'd1);

        // Reset during service, then confirm the mask came back all ones.
        pulse_rst();
        repeat (6) cycle();
        chk("s6_mask_ff", 32'(exception), 32'd0);
        chk("s6_pend0_again", 32'(pending[0]), 32'd1);

        // Randomized traffic.
        irq_n = '1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) pulse_rst();
            if ($urandom_range(0, 7) == 0) begin
                int idx;
                idx = int'($urandom_range(0, NCH - 1));
                irq_n[idx] = ~irq_n[idx];
            end
            ie = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) begin
                exc_valid = 1'b1;
                exc_vec   = VW'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 29) == 0) begin
                mask_we    = 1'b1;
                mask_wdata = NCH'($urandom_range(0, 255));
            end
            ack = exception ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            eoi = busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
